pkt_tx_arbiter: RTL and testbench

PKT_TX_ARBITER -- requirements
Module: pkt_tx_arbiter

---
 rtl/pkt_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_pkt_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_arbiter.sv
// pkt_tx_arbiter
//   Two-source round-robin arbiter that shares one transmit path. Once a
//   source is granted, its packet words and metadata are forwarded with one
//   cycle of latency until a tail word arrives or the source stays idle
//   for `timeout` cycles.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   req0/req1                  per-source request for one packet
//   grant0/grant1              per-source ownership, held for the whole packet
//   in{0,1}_pkt_valid/_pkt     per-source packet word (bits [138:136] = type)
//   in{0,1}_metadata_valid/_metadata  per-source descriptor, with the head word
//   out_pkt_valid/out_pkt      registered word toward transmit
//   out_metadata_valid/_metadata      registered descriptor toward transmit
//   transmit_usedw             transmit FIFO fill level
//   pkt_cnt0/pkt_cnt1          tail words forwarded per source (wrapping)
//   timeout_err                one-cycle pulse per timeout revocation
module pkt_tx_arbiter #(
    parameter int unsigned width_meta = 288,
    parameter logic [7:0]  usedw_th   = 8'd160,
    parameter logic [7:0]  timeout    = 8'd255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    output logic                  grant0,
    output logic                  grant1,
    input  logic                  in0_pkt_valid,
    input  logic [138:0]          in0_pkt,
    input  logic                  in0_metadata_valid,
    input  logic [width_meta-1:0] in0_metadata,
    input  logic                  in1_pkt_valid,
    input  logic [138:0]          in1_pkt,
    input  logic                  in1_metadata_valid,
    input  logic [width_meta-1:0] in1_metadata,
    output logic                  out_pkt_valid,
    output logic [138:0]          out_pkt,
    output logic                  out_metadata_valid,
    output logic [width_meta-1:0] out_metadata,
    input  logic [7:0]            transmit_usedw,
    output logic [31:0]           pkt_cnt0,
    output logic [31:0]           pkt_cnt1,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2
    } state_t;

    localparam logic [2:0] TYPE_TAIL = 3'b110;

    state_t                state_q;
    logic                  grant0_q, grant1_q;
    logic                  last_q;           // 1: source 1 was served last
    logic [7:0]            idle_q;
    logic                  out_pkt_valid_q, out_meta_valid_q;
    logic [138:0]          out_pkt_q;
    logic [width_meta-1:0] out_meta_q;
    logic [31:0]           pkt_cnt0_q, pkt_cnt1_q;
    logic                  timeout_err_q;

    // Granted source's inputs; everything is zero in IDLE so the other
    // source can never leak through.
    logic                  src_pv, src_mv;
    logic [138:0]          src_pkt;
    logic [width_meta-1:0] src_md;

    always_comb begin
        src_pv  = 1'b0;
        src_mv  = 1'b0;
        src_pkt = '0;
        src_md  = '0;
        if (state_q == SEND0) begin
            src_pv  = in0_pkt_valid;
            src_mv  = in0_metadata_valid;
            src_pkt = in0_pkt;
            src_md  = in0_metadata;
        end else if (state_q == SEND1) begin
            src_pv  = in1_pkt_valid;
            src_mv  = in1_metadata_valid;
            src_pkt = in1_pkt;
            src_md  = in1_metadata;
        end
    end

    logic       is_tail;
    logic [7:0] idle_inc;
    logic       pick1;       // arbitration winner is source 1
    logic       can_grant;

    assign is_tail   = src_pv && (src_pkt[138:136] == TYPE_TAIL);
    assign idle_inc  = idle_q + 8'd1;
    // Both requesting: the one not served last wins; otherwise the requester.
    assign pick1     = (req0 && req1) ? ~last_q : req1;
    assign can_grant = (req0 || req1) && (transmit_usedw < usedw_th);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            grant0_q         <= 1'b0;
            grant1_q         <= 1'b0;
            last_q           <= 1'b1;
            idle_q           <= '0;
            out_pkt_valid_q  <= 1'b0;
            out_pkt_q        <= '0;
            out_meta_valid_q <= 1'b0;
            out_meta_q       <= '0;
            pkt_cnt0_q       <= '0;
            pkt_cnt1_q       <= '0;
            timeout_err_q    <= 1'b0;
        end else begin
            timeout_err_q    <= 1'b0;
            out_pkt_valid_q  <= src_pv;
            out_meta_valid_q <= src_mv;
            if (state_q != IDLE) begin
                out_pkt_q  <= src_pkt;
                out_meta_q <= src_md;
            end
            case (state_q)
                IDLE: begin
                    if (can_grant) begin
                        state_q  <= pick1 ? SEND1 : SEND0;
                        grant0_q <= ~pick1;
                        grant1_q <= pick1;
                        last_q   <= pick1;
                        idle_q   <= '0;
                    end
                end
                SEND0, SEND1: begin
                    // A tail wins over a coincident timeout: it is valid, so
                    // the idle counter cannot advance in that cycle anyway.
                    if (is_tail) begin
                        state_q  <= IDLE;
                        grant0_q <= 1'b0;
                        grant1_q <= 1'b0;
                        idle_q   <= '0;
                        if (state_q == SEND0) pkt_cnt0_q <= pkt_cnt0_q + 32'd1;
                        else                  pkt_cnt1_q <= pkt_cnt1_q + 32'd1;
                    end else if (src_pv) begin
                        idle_q <= '0;
                    end else if (idle_inc == timeout) begin
                        state_q       <= IDLE;
                        grant0_q      <= 1'b0;
                        grant1_q      <= 1'b0;
                        idle_q        <= '0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        idle_q <= idle_inc;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    grant0_q <= 1'b0;
                    grant1_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant0             = grant0_q;
    assign grant1             = grant1_q;
    assign out_pkt_valid      = out_pkt_valid_q;
    assign out_pkt            = out_pkt_q;
    assign out_metadata_valid = out_meta_valid_q;
    assign out_metadata       = out_meta_q;
    assign pkt_cnt0           = pkt_cnt0_q;
    assign pkt_cnt1           = pkt_cnt1_q;
    assign timeout_err        = timeout_err_q;

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Randomized bench for pkt_tx_arbiter with a cycle-level reference model.
module tb_pkt_tx_arbiter;

    localparam int WM = 288;

    logic          clk = 1'b0;
    logic          reset;
    logic          req[2];
    logic          pv[2];
    logic [138:0]  pk[2];
    logic          mv[2];
    logic [WM-1:0] md[2];
    logic [7:0]    usedw;
    logic          grant0, grant1, out_pkt_valid, out_metadata_valid, timeout_err;
    logic [138:0]  out_pkt;
    logic [WM-1:0] out_metadata;
    logic [31:0]   pkt_cnt0, pkt_cnt1;

    always #5 clk = ~clk;

    pkt_tx_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req[0]), .req1(req[1]),
        .grant0(grant0), .grant1(grant1),
        .in0_pkt_valid(pv[0]), .in0_pkt(pk[0]),
        .in0_metadata_valid(mv[0]), .in0_metadata(md[0]),
        .in1_pkt_valid(pv[1]), .in1_pkt(pk[1]),
        .in1_metadata_valid(mv[1]), .in1_metadata(md[1]),
        .out_pkt_valid(out_pkt_valid), .out_pkt(out_pkt),
        .out_metadata_valid(out_metadata_valid), .out_metadata(out_metadata),
        .transmit_usedw(usedw),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
        .timeout_err(timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [WM-1:0] got, input logic [WM-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int            owner;      // -1 none, else granted source
    int            last;       // source served last
    int            idle;
    logic [31:0]   cnt[2];
    logic          e_pv, e_mv, e_terr;
    logic [138:0]  e_pk;
    logic [WM-1:0] e_md;

    task automatic model_reset();
        owner = -1; last = 1; idle = 0;
        cnt[0] = '0; cnt[1] = '0;
        e_pv = 0; e_mv = 0; e_terr = 0; e_pk = '0; e_md = '0;
    endtask

    task automatic model_step();
        if (!reset) begin
            model_reset();
            return;
        end
        e_terr = 0;
        if (owner < 0) begin
            e_pv = 0; e_mv = 0;
            if ((req[0] || req[1]) && usedw < 8'd160) begin
                owner = (req[0] && req[1]) ? 1 - last : (req[0] ? 0 : 1);
                last  = owner;
                idle  = 0;
            end
        end else begin
            e_pv = pv[owner]; e_pk = pk[owner];
            e_mv = mv[owner]; e_md = md[owner];
            if (pv[owner] && pk[owner][138:136] == 3'b110) begin
                cnt[owner] = cnt[owner] + 1;
                owner = -1;
            end else if (pv[owner]) begin
                idle = 0;
            end else begin
                idle++;
                if (idle == 255) begin
                    owner = -1;
                    e_terr = 1;
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    int req_mode  = 0;   // 0 random, 1 both, 2 only 0, 3 only 1
    int usedw_fix = -1;  // -1 random
    bit stall     = 0;   // granted source sends nothing
    int pos[2];
    int nmid[2];

    function automatic logic [135:0] rnd136();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [WM-1:0] rndmd();
        logic [WM-1:0] v;
        for (int i = 0; i < WM / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic gen_inputs();
        logic [2:0] ty;
        for (int n = 0; n < 2; n++) begin
            case (req_mode)
                1:       req[n] = 1'b1;
                2:       req[n] = (n == 0);
                3:       req[n] = (n == 1);
                default: req[n] = ($urandom_range(0, 3) != 0);
            endcase
            md[n] = rndmd();
            if (owner == n) begin
                if (!stall && $urandom_range(0, 3) != 0) begin
                    ty = (pos[n] == 0) ? 3'b101 : (pos[n] > nmid[n] ? 3'b110 : 3'b100);
                    pv[n] = 1'b1;
                    pk[n] = {ty, rnd136()};
                    mv[n] = (pos[n] == 0);
                    pos[n]++;
                end else begin
                    pv[n] = 1'b0;
                    pk[n] = {3'b100, rnd136()};
                    mv[n] = 1'b0;
                end
            end else begin
                // Non-granted source chatters, including tails, to prove it is ignored.
                pos[n]  = 0;
                nmid[n] = $urandom_range(0, 3);
                case ($urandom_range(0, 2))
                    0:       ty = 3'b101;
                    1:       ty = 3'b100;
                    default: ty = 3'b110;
                endcase
                pv[n] = $urandom_range(0, 1);
                pk[n] = {ty, rnd136()};
                mv[n] = $urandom_range(0, 1);
            end
        end
        usedw = (usedw_fix < 0) ? 8'($urandom_range(0, 200)) : 8'(usedw_fix);
    endtask

    task automatic compare_all();
        chk("grant0", WM'(grant0), WM'(owner == 0));
        chk("grant1", WM'(grant1), WM'(owner == 1));
        chk("out_pkt_valid", WM'(out_pkt_valid), WM'(e_pv));
        if (e_pv) chk("out_pkt", WM'(out_pkt), WM'(e_pk));
        chk("out_meta_valid", WM'(out_metadata_valid), WM'(e_mv));
        if (e_mv) chk("out_metadata", out_metadata, e_md);
        chk("pkt_cnt0", WM'(pkt_cnt0), WM'(cnt[0]));
        chk("pkt_cnt1", WM'(pkt_cnt1), WM'(cnt[1]));
        chk("timeout_err", WM'(timeout_err), WM'(e_terr));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        gen_inputs();
    endtask

    int  terr_seen;
    bit  found;

    initial begin
        reset = 1'b0;
        model_reset();
        pos[0] = 0; pos[1] = 0; nmid[0] = 0; nmid[1] = 0;
        req[0] = 0; req[1] = 0; pv[0] = 0; pv[1] = 0; mv[0] = 0; mv[1] = 0;
        pk[0] = '0; pk[1] = '0; md[0] = '0; md[1] = '0; usedw = '0;
        #12;
        compare_all();
        chk("rst_out_pkt", WM'(out_pkt), '0);
        chk("rst_out_meta", out_metadata, '0);
        @(negedge clk);
        reset = 1'b1;

        // Threshold: full FIFO blocks the grant, one below lets it through,
        // and a rise mid-packet does not stop the packet.
        req_mode = 3; usedw_fix = 160; gen_inputs();
        repeat (3) cyc();
        usedw_fix = 159; gen_inputs();
        cyc();
        chk("grant1_at_159", WM'(grant1), WM'(1));
        usedw_fix = 200;
        repeat (15) cyc();

        // Random traffic.
        usedw_fix = -1; req_mode = 0;
        repeat (1500) cyc();

        // Both requesting continuously: strict alternation.
        req_mode = 1; usedw_fix = 0;
        repeat (80) cyc();

        // Timeout: source 0 granted then silent; source 1 then takes over.
        req_mode = 2; stall = 1; terr_seen = 0;
        repeat (300) begin
            cyc();
            if (timeout_err) terr_seen++;
        end
        chk("timeout_pulses", WM'(terr_seen), WM'(1));
        stall = 0; req_mode = 1;
        repeat (20) cyc();

        // Counter wrap on source 1.
        req_mode = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (owner < 0) found = 1; else cyc();
        end
        force dut.pkt_cnt1_q = 32'hFFFFFFFF;
        #1 release dut.pkt_cnt1_q;
        cnt[1] = 32'hFFFFFFFF;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc();
            if (cnt[1] == 32'd0) found = 1;
        end
        chk("cnt1_wrapped", WM'(found), WM'(1));
        chk("cnt1_zero", WM'(pkt_cnt1), WM'(0));

        // Reset in the middle of a packet.
        req_mode = 1; usedw_fix = 0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc();
            if (owner >= 0 && pos[owner] >= 2 && pos[owner] <= nmid[owner]) found = 1;
        end
        chk("mid_pkt_reached", WM'(found), WM'(1));
        #2 reset = 1'b0;
        #1;
        chk("rst_grant0", WM'(grant0), '0);
        chk("rst_grant1", WM'(grant1), '0);
        chk("rst_opv", WM'(out_pkt_valid), '0);
        chk("rst_opk", WM'(out_pkt), '0);
        chk("rst_cnt0", WM'(pkt_cnt0), '0);
        model_reset();
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        chk("first_after_rst", WM'(grant0), WM'(1));
        repeat (100) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
